// File: rtl/sub_pkg.sv
// Shared types and defaults for the subtractor/adder family.
//   sub_state_t     : serial subtractor FSM states
//   SubWidthDefault : default operand width
//   SubWidthMin     : smallest supported operand width
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } sub_state_t;

    localparam int unsigned SubWidthDefault = 4;
    localparam int unsigned SubWidthMin     = 2;

endpackage

// File: rtl/full_subtractor_1b.sv
// One-bit full subtractor: d = a - b - bin.
// Ports:
//   a_i    : minuend bit
//   b_i    : subtrahend bit
//   bin_i  : borrow in
//   d_o    : difference bit
//   bout_o : borrow out
module full_subtractor_1b (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        // Borrow when b exceeds a, or when they match and a borrow is pending.
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule

// File: rtl/serial_subtractor_nb.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first, one bit per clock.
// A single full_subtractor_1b sits in a loop with a 1-bit borrow register.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o  : operand handshake (a_i, b_i, bin_i)
//   out_valid_o/out_ready_i: result handshake (diff_o, bout_o [, ovf_o])
//   diff_o              : a - b - bin mod 2^WIDTH, meaningful only with out_valid_o
//   bout_o              : unsigned borrow out
//   ovf_o               : signed overflow, only when SUB_OVF_FLAG_EN is defined
// Configuration macro: SUB_OVF_FLAG_EN adds the ovf_o port and the MSB capture logic.
module serial_subtractor_nb
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = SubWidthDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
`ifdef SUB_OVF_FLAG_EN
    output logic             ovf_o,
`endif
    output logic             bout_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             fs_d, fs_bout;
`ifdef SUB_OVF_FLAG_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    full_subtractor_1b u_fs (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .bin_i  (br_q),
        .d_o    (fs_d),
        .bout_o (fs_bout)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        br_d      = br_q;
        bout_d    = bout_q;
`ifdef SUB_OVF_FLAG_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    a_sr_d  = a_i;
                    b_sr_d  = b_i;
                    br_d    = bin_i;
                    cnt_d   = '0;
                    state_d = S_BUSY;
`ifdef SUB_OVF_FLAG_EN
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
`endif
                end
            end
            S_BUSY: begin
                a_sr_d    = a_sr_q >> 1;
                b_sr_d    = b_sr_q >> 1;
                diff_sr_d = {fs_d, diff_sr_q[WIDTH-1:1]};
                br_d      = fs_bout;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = S_DONE;
                    bout_d  = fs_bout;
`ifdef SUB_OVF_FLAG_EN
                    // fs_d is the bit landing in the diff MSB on this edge.
                    ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered so in_ready stays low throughout reset and rises on the first edge after.
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            diff_sr_q  <= '0;
            br_q       <= 1'b0;
            bout_q     <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            diff_sr_q  <= diff_sr_d;
            br_q       <= br_d;
            bout_q     <= bout_d;
`ifdef SUB_OVF_FLAG_EN
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q == S_DONE);
    assign diff_o      = diff_sr_q;
    assign bout_o      = bout_q;
`ifdef SUB_OVF_FLAG_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_nb.sv
// Directed bench for serial_subtractor_nb (WIDTH=4) with a result scoreboard.
module tb_serial_subtractor_nb;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_FLAG_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    serial_subtractor_nb #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .bin_i       (bin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .diff_o      (diff),
`ifdef SUB_OVF_FLAG_EN
        .ovf_o       (ovf),
`endif
        .bout_o      (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                   input logic bin_v);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, a_v} - {1'b0, b_v} - {{W{1'b0}}, bin_v};
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.ovf  = (a_v[W-1] != b_v[W-1]) && (e.diff[W-1] != a_v[W-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents operands for one accepting edge.
    task automatic start_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                            input logic bin_v, input bit push);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        a        = a_v;
        b        = b_v;
        bin      = bin_v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (push) sb.push_back(model(a_v, b_v, bin_v));
    endtask

    // Called just after the accepting edge; waits for out_valid and scores the result.
    task automatic collect(input string tag, output exp_t e);
        int n;
        n = 0;
        e = '0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_diff"}, 32'(diff), 32'(e.diff));
            check({tag, "_bout"}, 32'(bout), 32'(e.bout));
`ifdef SUB_OVF_FLAG_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic bin_v);
        exp_t e;
        start_op(a_v, b_v, bin_v, 1'b1);
        collect(tag, e);
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        bit   seen;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef SUB_OVF_FLAG_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic and wrap-around cases
        run_op("basic", 4'b0111, 4'b0011, 1'b0);
        check("basic_ref", 32'(model(4'b0111, 4'b0011, 1'b0)), 32'({4'b0100, 1'b0, 1'b0}));
        run_op("wrap0", 4'b0000, 4'b0001, 1'b0);
        run_op("wrap1", 4'b0101, 4'b0101, 1'b1);

        // Backpressure: result held, in_valid pulses ignored
        out_ready = 1'b0;
        start_op(4'b1100, 4'b0110, 1'b1, 1'b1);
        collect("bp", e);
        for (int i = 0; i < 5; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            in_valid = 1'b1;
            tick();
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_diff_stable", 32'(diff), 32'(e.diff));
            check("bp_bout_stable", 32'(bout), 32'(e.bout));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("bp_no_ghost", 32'(seen), 32'd0);

        // Abort: reset during the second BUSY cycle
        start_op(4'b1111, 4'b0001, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op("after_abort", 4'b1001, 4'b0010, 1'b0);

`ifdef SUB_OVF_FLAG_EN
        run_op("ovf_set", 4'b1000, 4'b0001, 1'b0);
        run_op("ovf_clr", 4'b0011, 4'b0001, 1'b0);
`endif

        // Random operands
        for (int i = 0; i < 6; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
        end

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
